// File: rtl/note_judge.sv
// Per-lane rhythm-game hit judge: note FIFOs, key edge detection, grading, score/combo.
// Optional macro NOTE_JUDGE_STRAY_PENALTY_EN turns stray presses into BOO judgements.
module note_judge #(
  parameter int LANES       = 4,
  parameter int DEPTH       = 8,
  parameter int TIME_W      = 16,
  parameter int WIN_PERFECT = 2,
  parameter int WIN_GOOD    = 6,
  localparam int LW         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              frame_tick,
  input  logic              note_valid,
  input  logic [LW-1:0]     note_lane,
  input  logic [TIME_W-1:0] note_time,
  output logic              note_ready,
  input  logic [LANES-1:0]  key_down,
  output logic              judge_valid,
  output logic [LW-1:0]     judge_lane,
  output logic [1:0]        judge_grade,
  output logic [TIME_W-1:0] now_frame,
  output logic [19:0]       score,
  output logic [9:0]        combo,
  output logic [9:0]        max_combo
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] G_MISS = 2'd0, G_GOOD = 2'd1, G_PERFECT = 2'd2, G_BOO = 2'd3;

  // Handshake: a note is accepted on a clock edge where note_valid && note_ready;
  // note_ready depends only on the fullness of the lane addressed by note_lane.

  logic [TIME_W-1:0]        mem_q [LANES][DEPTH];
  logic [AW:0]              rd_q [LANES];
  logic [AW:0]              wr_q [LANES];
  logic [AW:0]              rd_d [LANES];
  logic [AW:0]              wr_d [LANES];
  logic [LANES-1:0]         key_q, key_qq, press_q, press_d, miss_q, miss_d;
  logic [TIME_W-1:0]        now_q, now_d, now_inc;
  logic                     jv_q, jv_d;
  logic [LW-1:0]            jl_q, jl_d;
  logic [1:0]               jg_q, jg_d, grade;
  logic [19:0]              score_q, score_d;
  logic [20:0]              score_sum;
  logic [9:0]               combo_q, combo_d, maxc_q, maxc_d;
  logic [LANES-1:0]         empty, full, push, pop, press_clr, miss_clr, miss_set;
  logic [TIME_W-1:0]        head [LANES];
  logic signed [TIME_W-1:0] dnow [LANES];
  logic signed [TIME_W-1:0] dnext [LANES];
  logic                     found;
  logic [LW-1:0]            sel;
  int                       d_sel, a_sel;

  always_comb begin
    now_inc = now_q + TIME_W'(1);
    for (int l = 0; l < LANES; l++) begin
      empty[l] = (rd_q[l] == wr_q[l]);
      full[l]  = (rd_q[l][AW] != wr_q[l][AW]) && (rd_q[l][AW-1:0] == wr_q[l][AW-1:0]);
      head[l]  = mem_q[l][rd_q[l][AW-1:0]];
      // Modular difference reinterpreted as signed makes frame wrap transparent.
      dnow[l]  = $signed(head[l] - now_q);
      dnext[l] = $signed(head[l] - now_inc);
      miss_set[l] = frame_tick && !empty[l] && (int'(dnext[l]) < -WIN_GOOD);
    end
    note_ready = !full[note_lane];
    for (int l = 0; l < LANES; l++)
      push[l] = note_valid && note_ready && (note_lane == LW'(l));
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (press_q[l] || miss_q[l]) begin
        found = 1'b1;
        sel   = LW'(l);
      end
    end
    d_sel     = int'(dnow[sel]);
    a_sel     = (d_sel < 0) ? -d_sel : d_sel;
    pop       = '0;
    press_clr = '0;
    miss_clr  = '0;
    jv_d      = 1'b0;
    grade     = G_MISS;
    jl_d      = jl_q;
    jg_d      = jg_q;
    score_d   = score_q;
    score_sum = '0;
    combo_d   = combo_q;
    maxc_d    = maxc_q;
    if (found) begin
      if (press_q[sel]) begin
        press_clr[sel] = 1'b1;
        if (!empty[sel] && a_sel <= WIN_PERFECT) begin
          pop[sel] = 1'b1; jv_d = 1'b1; grade = G_PERFECT;
        end else if (!empty[sel] && a_sel <= WIN_GOOD) begin
          pop[sel] = 1'b1; jv_d = 1'b1; grade = G_GOOD;
        end else begin
`ifdef NOTE_JUDGE_STRAY_PENALTY_EN
          jv_d = 1'b1; grade = G_BOO;
`endif
        end
      end else begin
        // The miss flag is only a hint; the head may have been hit since.
        miss_clr[sel] = 1'b1;
        if (!empty[sel] && d_sel < -WIN_GOOD) begin
          pop[sel] = 1'b1; jv_d = 1'b1; grade = G_MISS;
        end
      end
    end
    if (jv_d) begin
      jl_d = sel;
      jg_d = grade;
      case (grade)
        G_PERFECT, G_GOOD: begin
          score_sum = {1'b0, score_q} + ((grade == G_PERFECT) ? 21'd3 : 21'd1);
          score_d   = score_sum[20] ? '1 : score_sum[19:0];
          combo_d   = (combo_q == '1) ? combo_q : combo_q + 10'd1;
          if (combo_d > maxc_q) maxc_d = combo_d;
        end
        G_MISS, G_BOO: combo_d = '0;
        default: combo_d = combo_q;
      endcase
    end
    for (int l = 0; l < LANES; l++) begin
      rd_d[l] = rd_q[l] + (AW+1)'(pop[l]);
      wr_d[l] = wr_q[l] + (AW+1)'(push[l]);
    end
    // A new edge or tick in the same cycle as service wins over the clear.
    press_d = (press_q & ~press_clr) | (key_q & ~key_qq);
    miss_d  = (miss_q & ~miss_clr) | miss_set;
    now_d   = frame_tick ? now_inc : now_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q   <= '0;
      key_qq  <= '0;
      press_q <= '0;
      miss_q  <= '0;
      now_q   <= '0;
      jv_q    <= 1'b0;
      jl_q    <= '0;
      jg_q    <= '0;
      score_q <= '0;
      combo_q <= '0;
      maxc_q  <= '0;
      for (int l = 0; l < LANES; l++) begin
        rd_q[l] <= '0;
        wr_q[l] <= '0;
      end
    end else begin
      key_q  <= key_down;
      key_qq <= key_q;
      if (clear) begin
        press_q <= '0;
        miss_q  <= '0;
        now_q   <= '0;
        jv_q    <= 1'b0;
        jl_q    <= '0;
        jg_q    <= '0;
        score_q <= '0;
        combo_q <= '0;
        maxc_q  <= '0;
        for (int l = 0; l < LANES; l++) begin
          rd_q[l] <= '0;
          wr_q[l] <= '0;
        end
      end else begin
        press_q <= press_d;
        miss_q  <= miss_d;
        now_q   <= now_d;
        jv_q    <= jv_d;
        jl_q    <= jl_d;
        jg_q    <= jg_d;
        score_q <= score_d;
        combo_q <= combo_d;
        maxc_q  <= maxc_d;
        for (int l = 0; l < LANES; l++) begin
          rd_q[l] <= rd_d[l];
          wr_q[l] <= wr_d[l];
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int l = 0; l < LANES; l++)
      if (push[l] && !clear) mem_q[l][wr_q[l][AW-1:0]] <= note_time;
  end

  assign judge_valid = jv_q;
  assign judge_lane  = jl_q;
  assign judge_grade = jg_q;
  assign now_frame   = now_q;
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = maxc_q;
endmodule
